// File: rtl/multdiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: FSM state encoding,
// default operand width and radix-4 Booth recode values.
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MULT = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Booth digit codes are the two's-complement value of the digit.
  localparam logic [2:0] BOOTH_ZERO = 3'b000;
  localparam logic [2:0] BOOTH_POS1 = 3'b001;
  localparam logic [2:0] BOOTH_POS2 = 3'b010;
  localparam logic [2:0] BOOTH_NEG2 = 3'b110;
  localparam logic [2:0] BOOTH_NEG1 = 3'b111;

  function automatic logic [2:0] booth_recode(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: booth_recode = BOOTH_POS1;
      3'b011:         booth_recode = BOOTH_POS2;
      3'b100:         booth_recode = BOOTH_NEG2;
      3'b101, 3'b110: booth_recode = BOOTH_NEG1;
      default:        booth_recode = BOOTH_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/divider_step.sv
// One iteration of unsigned restoring division: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_i};
    // A clear borrow bit means the divisor fitted; the difference is then < divisor.
    rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit. Define MULTDIV_BOOTH4_EN to multiply
// with radix-4 Booth recoding (WIDTH/2 iterations) instead of radix-2 shift-add.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_ITERS = WIDTH / 2;
`else
  localparam int MUL_ITERS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_ITERS);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     start, mul_iter, div_iter, mul_fin, div_fin;
  logic signed [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, pp;
  logic [WIDTH:0]           mplier_q, mplier_d;
  logic [WIDTH-1:0]         rem_q, quo_q, dvsr_q, rem_d, quo_d;
  logic                     qneg_q, dvz_q, dovf_q;
  logic [WIDTH-1:0]         result_q, result_d;
  logic                     exc_q, exc_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign start    = ctrl_MULT | ctrl_DIV;
  assign mul_iter = (state_q == ST_MULT) && (cnt_q != MUL_LAST);
  assign div_iter = (state_q == ST_DIV) && (cnt_q != DIV_LAST);
  // A new start takes priority over finishing, so an aborted op never commits.
  assign mul_fin  = (state_q == ST_MULT) && (cnt_q == MUL_LAST) && !start;
  assign div_fin  = (state_q == ST_DIV) && (cnt_q == DIV_LAST) && !start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) begin
      state_d = ST_MULT;
    end else if (ctrl_DIV) begin
      state_d = ST_DIV;
    end else begin
      case (state_q)
        ST_MULT: if (cnt_q == MUL_LAST) state_d = ST_DONE;
        ST_DIV:  if (cnt_q == DIV_LAST) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state_q == ST_MULT) || (state_q == ST_DIV);
    data_resultRDY = (state_q == ST_DONE);
  end

  always_comb begin
    cnt_d = start ? '0 : (busy ? cnt_q + CW'(1) : cnt_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pp = '0;
`ifdef MULTDIV_BOOTH4_EN
    case (booth_recode(mplier_q[2:0]))
      BOOTH_POS1: pp = mcand_q;
      BOOTH_NEG1: pp = -mcand_q;
      BOOTH_POS2: pp = mcand_q <<< 1;
      BOOTH_NEG2: pp = -(mcand_q <<< 1);
      default:    pp = '0;
    endcase
    mcand_d  = mcand_q <<< 2;
    mplier_d = mplier_q >> 2;
`else
    // The multiplier's sign bit carries negative weight in two's complement.
    if (mplier_q[1]) pp = (cnt_q == MUL_LAST - CW'(1)) ? -mcand_q : mcand_q;
    mcand_d  = mcand_q <<< 1;
    mplier_d = mplier_q >> 1;
`endif
    acc_d = acc_q + pp;
  end

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_d),
    .quo_o  (quo_d)
  );

  always_ff @(posedge clock) begin
    if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
      mplier_q <= {data_operandB, 1'b0};
      rem_q    <= '0;
      quo_q    <= magnitude(data_operandA);
      dvsr_q   <= magnitude(data_operandB);
      qneg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dvz_q    <= (data_operandB == '0);
      dovf_q   <= (data_operandA == MIN_INT) && (data_operandB == '1);
    end else if (mul_iter) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end else if (div_iter) begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end
  end

  always_comb begin
    result_d = result_q;
    exc_d    = exc_q;
    if (mul_fin) begin
      result_d = acc_q[WIDTH-1:0];
      exc_d    = (acc_q[2*WIDTH-1:WIDTH] != {WIDTH{acc_q[WIDTH-1]}});
    end else if (div_fin) begin
      if (dvz_q) begin
        result_d = '0;
        exc_d    = 1'b1;
      end else if (dovf_q) begin
        result_d = MIN_INT;
        exc_d    = 1'b1;
      end else begin
        result_d = apply_sign(quo_q, qneg_q);
        exc_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;

endmodule
